// File: rtl/uart_io_responder.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, a DATA/STATUS register pair and an RX interrupt.
// All state is clocked on posedge clock and cleared by the asynchronous active-low reset.
module uart_io_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'hFF10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] read_address,
  input  logic        read_enable,
  output logic [15:0] read_data,
  output logic        read_valid,
  input  logic [15:0] write_address,
  input  logic [15:0] write_data,
  input  logic        write_enable,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq,
  input  logic        reset_irq
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [15:0] BitLoad    = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLoad   = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [15:0] StatusAddr = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic rd_hit_data, rd_hit_status, wr_hit_data, wr_hit_status;

  assign rd_hit_data   = read_enable && (read_address == BASE_ADDR);
  assign rd_hit_status = read_enable && (read_address == StatusAddr);
  assign wr_hit_data   = write_enable && (write_address == BASE_ADDR);
  assign wr_hit_status = write_enable && (write_address == StatusAddr);

  logic unused_wdata;
  assign unused_wdata = ^{write_data[15:8], write_data[3:0]};

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CntW-1:0] tx_cnt_q, rx_cnt_q;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_drop_set, rx_ovr_set;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FullCnt);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullCnt);

  // RX FSM outputs
  logic rx_done, rx_ferr_set;

  // A full FIFO still accepts a push when the same cycle pops.
  assign rx_pop      = rd_hit_data && !rx_empty;
  assign rx_push     = rx_done && (!rx_full || rx_pop);
  assign rx_ovr_set  = rx_done && rx_full && !rx_pop;
  assign tx_push     = wr_hit_data && (!tx_full || tx_pop);
  assign tx_drop_set = wr_hit_data && tx_full && !tx_pop;

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_q] <= write_data[7:0];
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_tmr_q, tx_tmr_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_load;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!tx_empty) tx_load = 1'b1;
      end
      TxStart: begin
        if (tx_tmr_q == '0) begin
          tx_state_d = TxData;
          tx_tmr_d   = BitLoad;
          tx_bit_d   = '0;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      TxData: begin
        if (tx_tmr_q == '0) begin
          tx_tmr_d   = BitLoad;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      TxStop: begin
        if (tx_tmr_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!tx_empty) tx_load    = 1'b1;
          else           tx_state_d = TxIdle;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_mem[tx_rd_q];
      tx_tmr_d   = BitLoad;
      tx_state_d = TxStart;
    end
    case (tx_state_d)
      TxStart: tx_line_d = 1'b0;
      TxData:  tx_line_d = tx_shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------------
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_tmr_q, rx_tmr_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tmr_d    = rx_tmr_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_done     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_tmr_d   = HalfLoad;
        end
      end
      RxStart: begin
        if (rx_tmr_q == '0) begin
          // Line back high at mid start bit: treat as a glitch.
          if (!rx_sync_q) begin
            rx_state_d = RxData;
            rx_tmr_d   = BitLoad;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = RxIdle;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      RxData: begin
        if (rx_tmr_q == '0) begin
          rx_tmr_d   = BitLoad;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      RxStop: begin
        if (rx_tmr_q == '0) begin
          rx_done     = rx_sync_q;
          rx_ferr_set = !rx_sync_q;
          rx_state_d  = RxIdle;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky status, irq and read port
  // ---------------------------------------------------------------------------
  logic        rx_ovr_q, rx_ferr_q, tx_drop_q, irq_q;
  logic [15:0] read_data_q, read_data_d, status_word;
  logic        read_valid_q, read_valid_d;
  logic        tx_idle;

  assign tx_idle = tx_empty && (tx_state_q == TxIdle);

  always_comb begin
    status_word = {4'b0, 4'(rx_cnt_q), 1'b0, tx_drop_q, rx_ferr_q, rx_ovr_q,
                   tx_idle, tx_full, rx_full, !rx_empty};
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    if (rd_hit_data) begin
      read_valid_d = 1'b1;
      read_data_d  = rx_empty ? 16'h0000 : {8'h00, rx_mem[rx_rd_q]};
    end else if (rd_hit_status) begin
      read_valid_d = 1'b1;
      read_data_d  = status_word;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_cnt_q     <= '0;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
      tx_state_q   <= TxIdle;
      tx_tmr_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_line_q    <= 1'b1;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_tmr_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_ovr_q     <= 1'b0;
      rx_ferr_q    <= 1'b0;
      tx_drop_q    <= 1'b0;
      irq_q        <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PtrW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrW'(1);
      tx_cnt_q <= tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
      if (rx_push) rx_wr_q <= rx_wr_q + PtrW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrW'(1);
      rx_cnt_q <= rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);

      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;

      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;

      // Set beats a same-cycle W1C clear.
      if (rx_ovr_set)                           rx_ovr_q  <= 1'b1;
      else if (wr_hit_status && write_data[4])  rx_ovr_q  <= 1'b0;
      if (rx_ferr_set)                          rx_ferr_q <= 1'b1;
      else if (wr_hit_status && write_data[5])  rx_ferr_q <= 1'b0;
      if (tx_drop_set)                          tx_drop_q <= 1'b1;
      else if (wr_hit_status && write_data[6])  tx_drop_q <= 1'b0;

      if (rx_push)        irq_q <= 1'b1;
      else if (reset_irq) irq_q <= 1'b0;

      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign uart_tx    = tx_line_q;
  assign irq        = irq_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_uart_io_responder.sv
// Directed bench for uart_io_responder with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_io_responder;

  localparam logic [15:0] DataAddr = 16'hFF10;
  localparam logic [15:0] StatAddr = 16'hFF11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] read_address = '0;
  logic        read_enable = 1'b0;
  logic [15:0] read_data;
  logic        read_valid;
  logic [15:0] write_address = '0;
  logic [15:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        irq;
  logic        reset_irq = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  uart_io_responder #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (16'hFF10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .read_address  (read_address),
    .read_enable   (read_enable),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .write_address (write_address),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .irq           (irq),
    .reset_irq     (reset_irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One bus cycle, called at a falling edge; returns the registered read result.
  task automatic bus_op(input logic wr, input logic en, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output logic rvalid);
    if (wr) begin
      write_address = addr;
      write_data    = wdata;
      write_enable  = en;
    end else begin
      read_address = addr;
      read_enable  = en;
    end
    @(negedge clock);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    rdata  = read_data;
    rvalid = read_valid;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] wdata);
    logic [15:0] d;
    logic        v;
    bus_op(1'b1, 1'b1, addr, wdata, d, v);
  endtask

  task automatic rd_check(input string name, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    logic        v;
    bus_op(1'b0, 1'b1, addr, 16'h0, d, v);
    check(name, d, exp);
    check({name, "_valid"}, 16'(v), 16'h1);
  endtask

  // Drives one 8N1 frame; returns on the falling edge where the stop sample is taken.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clock);
    end
    uart_rx = stop;
    repeat (4) @(negedge clock);
    uart_rx = 1'b1;
  endtask

  task automatic tx_capture(output logic [7:0] b, output logic ok);
    logic st, sp;
    b  = '0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (ok) begin
      repeat (2) @(negedge clock);
      st = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clock);
        b[i] = uart_tx;
      end
      repeat (4) @(negedge clock);
      sp = uart_tx;
      ok = (st === 1'b0) && (sp === 1'b1);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        en;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [15:0] d;
    logic        v;
    logic [7:0]  b;
    logic        ok;
    logic        saw;
    logic [9:0]  frame;

    // Drain of the RX FIFO left as 33,44,77,88 by the simultaneous-event sequence.
    vecs[0]  = '{1'b0, 1'b1, StatAddr, 16'h0000, 16'h040B, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, DataAddr, 16'h0000, 16'h0033, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, StatAddr, 16'h0000, 16'h0309, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 16'hFF12, 16'h0000, 16'h0309, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, DataAddr, 16'h0000, 16'h0309, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, DataAddr, 16'h0000, 16'h0044, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, DataAddr, 16'h0000, 16'h0077, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, DataAddr, 16'h0000, 16'h0088, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, DataAddr, 16'h0000, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, StatAddr, 16'h0000, 16'h0008, 1'b1};
    vecs[10] = '{1'b1, 1'b1, DataAddr, 16'h1234, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 1'b1, StatAddr, 16'h0000, 16'h0000, 1'b1};
    vecs[12] = '{1'b0, 1'b0, StatAddr, 16'h0000, 16'h0000, 1'b0};

    // Power-on reset values
    repeat (3) @(negedge clock);
    check("por_uart_tx", 16'(uart_tx), 16'h1);
    check("por_irq", 16'(irq), 16'h0);
    check("por_read_data", read_data, 16'h0000);
    check("por_read_valid", 16'(read_valid), 16'h0);
    reset = 1'b1;
    @(negedge clock);

    // 1. Reset mid-TX frame with irq pending and a byte in the RX FIFO
    rx_send(8'h5A, 1'b1);
    repeat (2) @(negedge clock);
    check("rst_pre_irq", 16'(irq), 16'h1);
    wr(DataAddr, 16'h0000);
    repeat (10) @(negedge clock);
    check("rst_pre_tx_low", 16'(uart_tx), 16'h0);
    #2 reset = 1'b0;
    #1;
    check("rst_uart_tx", 16'(uart_tx), 16'h1);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_read_valid", 16'(read_valid), 16'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    rd_check("rst_status", StatAddr, 16'h0008);
    rd_check("rst_rx_empty", DataAddr, 16'h0000);
    check("rst_tx_idle_line", 16'(uart_tx), 16'h1);

    // 2. TX framing of A5, checked on every clock of every bit
    wr(DataAddr, 16'h00A5);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("tx_start_seen", 16'(ok), 16'h1);
    frame = 10'b11_0100_1010; // stop, A5 MSB..LSB, start; bit 0 goes first
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("tx_bit%0d_clk%0d", bi, c), 16'(uart_tx), 16'(frame[bi]));
        @(negedge clock);
      end
    end
    rd_check("tx_idle_after_40", StatAddr, 16'h0008);

    // 3. TX overflow: six back-to-back writes, the sixth is dropped
    fork
      begin
        for (int i = 1; i <= 6; i++) wr(DataAddr, 16'(i));
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          tx_capture(b, ok);
          check($sformatf("tx_ovf_frame%0d", k), 16'(ok), 16'h1);
          check($sformatf("tx_ovf_byte%0d", k), 16'(b), 16'(k));
        end
      end
    join
    saw = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (uart_tx === 1'b0) saw = 1'b1;
      @(negedge clock);
    end
    check("tx_ovf_no_sixth", 16'(saw), 16'h0);
    rd_check("tx_ovf_status", StatAddr, 16'h0048);
    wr(StatAddr, 16'h0040);
    rd_check("tx_drop_w1c", StatAddr, 16'h0008);

    // 4. RX + irq; TX is kept busy so tx_idle reads 0
    wr(DataAddr, 16'h00C3);
    wr(DataAddr, 16'h003C);
    rx_send(8'h3C, 1'b1);
    repeat (2) @(negedge clock);
    check("rx_irq_set", 16'(irq), 16'h1);
    rd_check("rx_status", StatAddr, 16'h0101);
    rd_check("rx_data", DataAddr, 16'h003C);
    @(negedge clock);
    check("rx_valid_pulse_end", 16'(read_valid), 16'h0);
    reset_irq = 1'b1;
    @(negedge clock);
    reset_irq = 1'b0;
    check("rx_irq_ack", 16'(irq), 16'h0);
    repeat (60) @(negedge clock);

    // 5. RX boundaries: glitch, overflow, framing error
    uart_rx = 1'b0;
    @(negedge clock);
    uart_rx = 1'b1;
    repeat (12) @(negedge clock);
    rd_check("glitch_status", StatAddr, 16'h0008);
    check("glitch_irq", 16'(irq), 16'h0);
    for (int i = 1; i <= 5; i++) rx_send(8'(8'h11 * i), 1'b1);
    repeat (2) @(negedge clock);
    rd_check("rx_full_status", StatAddr, 16'h041B);
    check("rx_full_irq", 16'(irq), 16'h1);
    rx_send(8'h66, 1'b0);
    repeat (2) @(negedge clock);
    rd_check("rx_ferr_status", StatAddr, 16'h043B);

    // 6. Simultaneous events
    wr(StatAddr, 16'h0030);
    rd_check("w1c_rx_status", StatAddr, 16'h040B);
    rx_send(8'h77, 1'b1);
    // This read is sampled on the same edge as the 0x77 push.
    rd_check("sim_pop_data", DataAddr, 16'h0011);
    rd_check("sim_pop_status", StatAddr, 16'h040B);
    reset_irq = 1'b1;
    @(negedge clock);
    reset_irq = 1'b0;
    check("sim_irq_cleared", 16'(irq), 16'h0);
    rd_check("sim_pop2_data", DataAddr, 16'h0022);
    rx_send(8'h88, 1'b1);
    reset_irq = 1'b1;
    @(negedge clock);
    reset_irq = 1'b0;
    check("sim_irq_set_wins", 16'(irq), 16'h1);
    @(negedge clock);
    check("sim_irq_holds", 16'(irq), 16'h1);

    // Register-access table
    for (int i = 0; i < 13; i++) begin
      bus_op(vecs[i].wr, vecs[i].en, vecs[i].addr, vecs[i].wdata, d, v);
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_valid", i), 16'(v), 16'(vecs[i].exp_valid));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
